axi_lite_ram: RTL and testbench

AXI-lite responder (slave) memory model that terminates the shared memory port driven by the IFU/LSU arbiter. It accepts one read and one write transaction at a time through independent channels. Responses come back after a programmable latency. Byte-lane write strobes are honoured, and out-of-range accesses are flagged. The block is the sequential endpoint the arbiter's `araddr_o`/`awaddr_o`/`wdata_o` side connects to.

---
 rtl/axi_lite_ram.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_axi_lite_ram.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ram.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_ram
// Purpose  : AXI-lite responder memory model. Independent read and write
//            channels, one outstanding transaction each. Responses arrive
//            after a programmable latency. Byte-lane strobes are honoured,
//            and out-of-range accesses return SLVERR on writes and zero data
//            on reads.
// Ports    : clk_i / rst_i (async, active-low)
//            AR: araddr_i, arvalid_i, arready_o
//            R : rdata_o, rvalid_o, rready_i
//            AW: awaddr_i, awvalid_i, awready_o
//            W : wdata_i, wstrb_i, wvalid_i, wready_o
//            B : bresp_o, bvalid_o, bready_i
// Options  : RAM_RANDOM_DELAY_EN - adds 0..3 LFSR-driven cycles to each
//            response latency
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_ram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    MEM_DEPTH  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = $clog2(LATENCY + 4);

    localparam logic [ADDR_WIDTH-1:0] c_span        = ADDR_WIDTH'(4 * MEM_DEPTH);
    localparam logic [1:0]            c_resp_okay   = 2'b00;
    localparam logic [1:0]            c_resp_slverr = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rstate_t;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_HAVE_AW = 3'd1,
        W_HAVE_W  = 3'd2,
        W_WAIT    = 3'd3,
        W_RESP    = 3'd4
    } wstate_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // ------------------------------------------------------------------------
    // Latency reload value. The counter is loaded with (latency - 1) so that a
    // handshake at edge T produces the response at edge T + latency.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] w_lat_load;

`ifdef RAM_RANDOM_DELAY_EN
    logic [3:0] r_lfsr;

    // Fibonacci LFSR, x^4 + x^3 + 1
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lfsr <= 4'b1001;
        end else begin
            r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
        end
    end

    assign w_lat_load = CNT_W'(LATENCY - 1) + CNT_W'(r_lfsr[1:0]);
`else
    assign w_lat_load = CNT_W'(LATENCY - 1);
`endif

    // ------------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------------
    rstate_t               r_rstate;
    rstate_t               w_rstate_nxt;
    logic [CNT_W-1:0]      r_rcnt;
    logic [CNT_W-1:0]      w_rcnt_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_rcap;
    logic                  w_ar_rdy;
    logic                  w_ar_hs;
    logic [ADDR_WIDTH-1:0] w_roff;
    logic                  w_rin;
    logic [IDX_W-1:0]      w_ridx;

    assign w_ar_rdy  = (r_rstate == R_IDLE);
    assign w_ar_hs   = arvalid_i & w_ar_rdy;
    // Gating with rst_i keeps the ready low while reset is held even though
    // the state register already sits in idle.
    assign arready_o = w_ar_rdy & rst_i;
    assign rvalid_o  = (r_rstate == R_RESP);
    assign rdata_o   = r_rdata;

    // Unsigned wrap makes addresses below BASE_ADDR land above c_span.
    assign w_roff = r_raddr - BASE_ADDR;
    assign w_rin  = (w_roff < c_span);
    assign w_ridx = w_roff[IDX_W+1:2];

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rcnt_nxt   = r_rcnt;
        w_rcap       = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (arvalid_i) begin
                    w_rstate_nxt = R_WAIT;
                    w_rcnt_nxt   = w_lat_load;
                end
            end
            R_WAIT: begin
                if (r_rcnt == '0) begin
                    w_rstate_nxt = R_RESP;
                    w_rcap       = 1'b1;
                end else begin
                    w_rcnt_nxt = r_rcnt - 1'b1;
                end
            end
            R_RESP: begin
                if (rready_i) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rstate <= R_IDLE;
            r_rcnt   <= '0;
            r_raddr  <= '0;
            r_rdata  <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_rcnt   <= w_rcnt_nxt;
            if (w_ar_hs) begin
                r_raddr <= araddr_i;
            end
            // Non-blocking read of the array returns pre-write data when a
            // write commits to the same word on this edge.
            if (w_rcap) begin
                r_rdata <= w_rin ? r_mem[w_ridx] : '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------------
    wstate_t               r_wstate;
    wstate_t               w_wstate_nxt;
    logic [CNT_W-1:0]      r_wcnt;
    logic [CNT_W-1:0]      w_wcnt_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [1:0]            r_bresp;
    logic                  w_wcommit;
    logic                  w_aw_rdy;
    logic                  w_w_rdy;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic [ADDR_WIDTH-1:0] w_woff;
    logic                  w_win;
    logic [IDX_W-1:0]      w_widx;
    logic                  w_mem_we;

    assign w_aw_rdy  = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_W);
    assign w_w_rdy   = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_AW);
    assign w_aw_hs   = awvalid_i & w_aw_rdy;
    assign w_w_hs    = wvalid_i & w_w_rdy;
    assign awready_o = w_aw_rdy & rst_i;
    assign wready_o  = w_w_rdy & rst_i;
    assign bvalid_o  = (r_wstate == W_RESP);
    assign bresp_o   = r_bresp;

    assign w_woff   = r_waddr - BASE_ADDR;
    assign w_win    = (w_woff < c_span);
    assign w_widx   = w_woff[IDX_W+1:2];
    assign w_mem_we = w_wcommit & w_win;

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wcnt_nxt   = r_wcnt;
        w_wcommit    = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_nxt = W_WAIT;
                    w_wcnt_nxt   = w_lat_load;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_HAVE_AW;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_w_hs) begin
                    w_wstate_nxt = W_WAIT;
                    w_wcnt_nxt   = w_lat_load;
                end
            end
            W_HAVE_W: begin
                if (w_aw_hs) begin
                    w_wstate_nxt = W_WAIT;
                    w_wcnt_nxt   = w_lat_load;
                end
            end
            W_WAIT: begin
                if (r_wcnt == '0) begin
                    w_wstate_nxt = W_RESP;
                    w_wcommit    = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt - 1'b1;
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wstate <= W_IDLE;
            r_wcnt   <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= c_resp_okay;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_wcnt   <= w_wcnt_nxt;
            if (w_aw_hs) begin
                r_waddr <= awaddr_i;
            end
            if (w_w_hs) begin
                r_wdata <= wdata_i;
                r_wstrb <= wstrb_i;
            end
            if (w_wcommit) begin
                r_bresp <= w_win ? c_resp_okay : c_resp_slverr;
            end
        end
    end

    // Array storage survives reset by design.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_widx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // Byte-offset bits of the address carry no meaning for word storage.
    logic w_unused_ok;
    assign w_unused_ok = ^{w_roff[1:0], w_woff[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_ram
// Purpose  : Self-checking bench for axi_lite_ram. Directed scenarios followed
//            by randomized read/write traffic compared against a word-level
//            reference memory held in an associative array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_ram;

    localparam int          LATENCY   = 1;
    localparam int          MEM_DEPTH = 4096;
    localparam logic [31:0] BASE      = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [int];

    always #5 clk = ~clk;

    axi_lite_ram #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .STRB_WIDTH (4),
        .MEM_DEPTH  (MEM_DEPTH),
        .BASE_ADDR  (BASE),
        .LATENCY    (LATENCY)
    ) u_dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .araddr_i  (araddr),
        .arvalid_i (arvalid),
        .arready_o (arready),
        .rdata_o   (rdata),
        .rvalid_o  (rvalid),
        .rready_i  (rready),
        .awaddr_i  (awaddr),
        .awvalid_i (awvalid),
        .awready_o (awready),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .bresp_o   (bresp),
        .bvalid_o  (bvalid),
        .bready_i  (bready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * MEM_DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (!in_range(a)) return 32'h0;
        if (model.exists(widx(a))) return model[widx(a)];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        logic [31:0] old;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) mask[8*b +: 8] = 8'hFF;
        end
        old = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
        model[widx(a)] = (old & ~mask) | (d & mask);
    endtask

    // w_lead: cycles W is presented before AW. abort: reset while waiting.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, input bit abort);
        bit aw_done, w_done, fa, fw;
        int cyc, k;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        wdata   = d;
        wstrb   = s;
        wvalid  = 1'b1;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (cyc >= w_lead && !aw_done) begin
                awaddr  = a;
                awvalid = 1'b1;
            end
            fa = awvalid && awready;
            fw = wvalid && wready;
            tick();
            cyc++;
            if (fa) begin
                aw_done = 1'b1;
                awvalid = 1'b0;
            end
            if (fw) begin
                w_done = 1'b1;
                wvalid = 1'b0;
                if (!aw_done) check("w_first_ready", 32'({awready, wready}), 32'h2);
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("wr_accept", 32'({aw_done, w_done}), 32'h3);
        if (abort) begin
            rst_n = 1'b0;
            #1;
            check("rst_mid_write", 32'({bvalid, awready, wready, arready}), 32'h0);
            tick();
            tick();
            check("rst_hold_bvalid", 32'(bvalid), 32'h0);
            rst_n = 1'b1;
            tick();
            check("rst_release_ready", 32'({arready, awready, wready}), 32'h7);
        end else begin
            k = 0;
            while (!bvalid && k < 20) begin
                tick();
                k++;
            end
            check("b_latency", 32'(k), 32'(LATENCY));
            check("bresp", 32'(bresp), in_range(a) ? 32'h0 : 32'h2);
            if (in_range(a)) model_write(a, d, s);
            bready = 1'b1;
            tick();
            bready = 1'b0;
            check("b_done", 32'({bvalid, awready, wready}), 32'h3);
        end
    endtask

    // hold: cycles of rready=0 back-pressure once rvalid is seen.
    task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] got);
        int k;
        bit fa;
        araddr  = a;
        arvalid = 1'b1;
        k       = 0;
        fa      = 1'b0;
        while (!fa && k < 50) begin
            fa = arready;
            tick();
            k++;
        end
        arvalid = 1'b0;
        check("ar_accept", 32'(fa), 32'h1);
        k = 0;
        while (!rvalid && k < 20) begin
            tick();
            k++;
        end
        check("r_latency", 32'(k), 32'(LATENCY));
        got = rdata;
        check("rdata", rdata, exp_read(a));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("r_hold", 32'({rvalid, arready}), 32'h2);
            check("r_stable", rdata, got);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("r_done", 32'({rvalid, arready}), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        bit          oor;

        // Reset state
        repeat (3) tick();
        check("reset_ctrl", 32'({arready, awready, wready, rvalid, bvalid, bresp}), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_reset_ready", 32'({arready, awready, wready}), 32'h7);

        // Write then read
        axi_write(32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
        axi_read(32'h8000_0010, 0, got);
        check("write_read", got, 32'hCAFE_F00D);

        // Byte-lane write
        axi_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 1'b0);
        axi_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, 1'b0);
        axi_read(32'h8000_0020, 0, got);
        check("byte_lane", got, 32'h11BB_33DD);

        // W ahead of AW by three cycles
        axi_write(32'h8000_0030, 32'h1357_9BDF, 4'hF, 3, 1'b0);
        axi_read(32'h8000_0030, 0, got);
        check("w_before_aw", got, 32'h1357_9BDF);

        // Out of range, including the word just past the end (must not alias word 0)
        axi_write(BASE, 32'h5A5A_A5A5, 4'hF, 0, 1'b0);
        axi_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        axi_write(BASE + 4 * MEM_DEPTH, 32'hDEAD_0000, 4'hF, 0, 1'b0);
        axi_read(BASE + 4 * MEM_DEPTH, 0, got);
        check("oor_read", got, 32'h0);
        axi_read(BASE, 0, got);
        check("oor_no_alias", got, 32'h5A5A_A5A5);

        // Read back-pressure
        axi_read(32'h8000_0010, 5, got);

        // Reset while the write is waiting; array keeps pre-write data
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b1);
        axi_read(32'h8000_0010, 0, got);
        check("rst_keeps_data", got, 32'hCAFE_F00D);

        // Randomized traffic against the reference memory
        for (int i = 0; i < 16; i++) begin
            axi_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            oor = ($urandom_range(0, 7) == 0);
            if (oor) begin
                case ($urandom_range(0, 2))
                    0:       a = BASE - 32'(4 * $urandom_range(1, 8));
                    1:       a = BASE + 32'(4 * MEM_DEPTH) + 32'(4 * $urandom_range(0, 8));
                    default: a = 32'($urandom_range(0, 32'h7FFF_0000));
                endcase
            end else begin
                a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 0) begin
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'b0);
            end else begin
                axi_read(a, $urandom_range(0, 2), got);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
